// File: rtl/bch_corr_pkg.sv
// Shared types and sizing helpers for the BCH error corrector.
// Optional stats ports are enabled with BCH_CORR_STATS_EN.
package bch_corr_pkg;

  typedef enum logic {
    W_IDLE,
    W_FILL
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    CORRECT
  } rd_state_t;

  function automatic int ceil_div(
    input int num,
    input int den
  );
    return (num + den - 1) / den;
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bch_err_corrector_if.sv
// Data/error stream bundle between BCH decoder and corrector.
// BCH_CORR_STATS_EN adds corr_bits and cnt_mismatch.
interface bch_err_corrector_if #(
  parameter int BITS = 8
) ();

  logic [BITS-1:0] data_in;
  logic            start_in;
  logic [BITS-1:0] err_in;
  logic            err_first;
  logic            err_last;
  logic            err_valid;
  logic [7:0]      err_cnt;
  logic [BITS-1:0] data_out;
  logic            out_valid;
  logic            out_first;
  logic            out_last;
  logic            overflow;
  logic            underflow;
  logic            proto_err;
`ifdef BCH_CORR_STATS_EN
  logic [15:0]     corr_bits;
  logic            cnt_mismatch;
`endif

  modport master (
    output data_in, start_in, err_in,
    output err_first, err_last, err_valid,
    output err_cnt,
    input  data_out, out_valid,
    input  out_first, out_last,
    input  overflow, underflow, proto_err
`ifdef BCH_CORR_STATS_EN
    , input corr_bits, cnt_mismatch
`endif
  );

  modport slave (
    input  data_in, start_in, err_in,
    input  err_first, err_last, err_valid,
    input  err_cnt,
    output data_out, out_valid,
    output out_first, out_last,
    output overflow, underflow, proto_err
`ifdef BCH_CORR_STATS_EN
    , output corr_bits, cnt_mismatch
`endif
  );

endinterface

// File: rtl/bch_corr_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port.
// Contents are not reset.
module bch_corr_ram
  import bch_corr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1072,
  localparam int AW   = idx_w(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/bch_err_corrector.sv
// Buffers raw codewords and XORs them with the BCH error stream.
// Define BCH_CORR_STATS_EN for corr_bits / cnt_mismatch reporting.
module bch_err_corrector
  import bch_corr_pkg::*;
#(
  parameter int DATA_BITS = 4288,
  parameter int BITS      = 8,
  parameter int CW_SLOTS  = 2
) (
  input logic           clk_in,
  input logic           rst_n,
  bch_err_corrector_if.slave bus
);

  localparam int DATA_WORDS = ceil_div(DATA_BITS, BITS);
  localparam int DEPTH = CW_SLOTS * DATA_WORDS;
  localparam int SW = idx_w(CW_SLOTS);
  localparam int IW = idx_w(DATA_WORDS);
  localparam int AW = idx_w(DEPTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_WORDS - 1);

  function automatic logic [AW-1:0] base(
    input logic [SW-1:0] s
  );
    return AW'(s) * AW'(DATA_WORDS);
  endfunction

  wr_state_t w_state;
  rd_state_t r_state;
  logic [SW-1:0] wr_slot, rd_slot;
  logic [IW-1:0] wr_idx, rd_idx, w_idx;
  logic [CW_SLOTS-1:0] full, set_m, clr_m;
  logic skip;

  logic w_last, w_open, w_proto;
  logic w_done, w_next_ok, w_ovf, we;
  logic r_hit, r_accept, r_under;
  logic r_step, rd_en, r_done, r_proto;
  logic [AW-1:0] wa, ra;
  logic [BITS-1:0] ram_q, err_d;
  logic v_d, f_d, l_d;

  logic [BITS-1:0] data_q;
  logic vld_q, fst_q, lst_q;
  logic ovf_q, unf_q, prt_q;

  assign w_last = wr_idx == LAST_IDX;
  assign w_open = (w_state == W_IDLE)
    && bus.start_in && !full[wr_slot];
  assign w_proto = (w_state == W_FILL)
    && bus.start_in && !w_last;
  assign w_done = (w_state == W_FILL) && w_last;
  assign w_next_ok = !full[wr_slot + SW'(1)];
  assign w_ovf = bus.start_in
    && (((w_state == W_IDLE) && full[wr_slot])
     || (w_done && !w_next_ok));
  assign we = w_open || (w_state == W_FILL);
  assign w_idx = (w_open || w_proto) ? '0 : wr_idx;
  assign wa = base(wr_slot) + AW'(w_idx);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      w_state <= W_IDLE;
      wr_slot <= '0;
      wr_idx  <= '0;
    end else begin
      case (w_state)
        W_IDLE: if (w_open) begin
          wr_idx  <= IW'(1);
          w_state <= W_FILL;
        end
        W_FILL: begin
          if (w_proto) begin
            wr_idx <= IW'(1);
          end else if (w_last) begin
            wr_slot <= wr_slot + SW'(1);
            wr_idx  <= '0;
            // a start on the closing word opens the next slot
            if (!(bus.start_in && w_next_ok))
              w_state <= W_IDLE;
          end else begin
            wr_idx <= wr_idx + IW'(1);
          end
        end
      endcase
    end
  end

  assign r_hit = (r_state == R_IDLE) && !skip
    && bus.err_valid && bus.err_first;
  assign r_accept = r_hit && full[rd_slot];
  assign r_under  = r_hit && !full[rd_slot];
  assign r_step = (r_state == CORRECT) && bus.err_valid;
  assign rd_en  = r_accept || r_step;
  assign r_done = rd_en && bus.err_last;
  assign r_proto = r_step && bus.err_first;

  always_comb begin
    ra = base(rd_slot);
    unique case (1'b1)
      r_accept: ra = base(rd_slot);
      default:  ra = base(rd_slot) + AW'(rd_idx);
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= R_IDLE;
      rd_slot <= '0;
      rd_idx  <= '0;
      skip    <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (skip && bus.err_valid && bus.err_last)
            skip <= 1'b0;
          if (r_under && !bus.err_last)
            skip <= 1'b1;
          if (r_accept) begin
            rd_idx <= IW'(1);
            if (bus.err_last)
              rd_slot <= rd_slot + SW'(1);
            else
              r_state <= CORRECT;
          end
        end
        CORRECT: if (bus.err_valid) begin
          rd_idx <= rd_idx + IW'(1);
          if (bus.err_last) begin
            rd_slot <= rd_slot + SW'(1);
            r_state <= R_IDLE;
          end
        end
      endcase
    end
  end

  // set wins over clear: a same-cycle free+fill ends full
  always_comb begin
    set_m = '0;
    clr_m = '0;
    if (w_done) set_m[wr_slot] = 1'b1;
    if (r_done) clr_m[rd_slot] = 1'b1;
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      full  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      prt_q <= 1'b0;
    end else begin
      full  <= (full & ~clr_m) | set_m;
      ovf_q <= ovf_q | w_ovf;
      unf_q <= unf_q | r_under;
      prt_q <= prt_q | w_proto | r_proto;
    end
  end

  bch_corr_ram #(
    .WIDTH (BITS),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk_in),
    .we    (we),
    .waddr (wa),
    .wdata (bus.data_in),
    .re    (rd_en),
    .raddr (ra),
    .rdata (ram_q)
  );

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      v_d    <= 1'b0;
      f_d    <= 1'b0;
      l_d    <= 1'b0;
      err_d  <= '0;
      vld_q  <= 1'b0;
      fst_q  <= 1'b0;
      lst_q  <= 1'b0;
      data_q <= '0;
    end else begin
      v_d    <= rd_en;
      f_d    <= r_accept;
      l_d    <= r_done;
      err_d  <= bus.err_in;
      vld_q  <= v_d;
      fst_q  <= f_d;
      lst_q  <= l_d;
      data_q <= v_d ? (ram_q ^ err_d) : '0;
    end
  end

  assign bus.data_out  = data_q;
  assign bus.out_valid = vld_q;
  assign bus.out_first = fst_q;
  assign bus.out_last  = lst_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
  assign bus.proto_err = prt_q;

`ifdef BCH_CORR_STATS_EN
  function automatic logic [15:0] pop(
    input logic [BITS-1:0] v
  );
    logic [15:0] n;
    n = '0;
    for (int i = 0; i < BITS; i++)
      n = n + 16'(v[i]);
    return n;
  endfunction

  logic [15:0] acc, acc_sum, bits_q;
  logic [7:0] cnt_lat;
  logic mis_q;

  assign acc_sum = (f_d ? 16'd0 : acc) + pop(err_d);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      bits_q  <= '0;
      cnt_lat <= '0;
      mis_q   <= 1'b0;
    end else begin
      if (r_accept) cnt_lat <= bus.err_cnt;
      if (v_d) acc <= acc_sum;
      mis_q <= 1'b0;
      if (v_d && l_d) begin
        bits_q <= acc_sum;
        mis_q  <= acc_sum != {8'd0, cnt_lat};
      end
    end
  end

  assign bus.corr_bits    = bits_q;
  assign bus.cnt_mismatch = mis_q;
`endif

endmodule

// File: tb/tb_bch_err_corrector.sv
// Scoreboard bench for bch_err_corrector: directed codewords,
// expected words queued at issue, compared by a negedge monitor.
module tb_bch_err_corrector;

  localparam int DW = 536;

  logic clk_in = 1'b0;
  logic rst_n  = 1'b0;
  always #5 clk_in = ~clk_in;

  bch_err_corrector_if #(.BITS(8)) bus ();

  bch_err_corrector #(
    .DATA_BITS (4288),
    .BITS      (8),
    .CW_SLOTS  (2)
  ) dut (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .bus    (bus.slave)
  );

  typedef struct {
    logic [7:0]  data;
    logic        first;
    logic        last;
    int          stamp;
    logic [15:0] bits;
    logic        mis;
  } exp_t;

  typedef struct {
    int          kind;
    logic [15:0] exp;
    string       name;
  } chk_t;

  exp_t exp_q[$];
  chk_t chk_q[$];
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit ignore_out = 1'b0;

  always @(posedge clk_in) cyc++;

  exp_t e;
  chk_t c;
  logic [15:0] act;

  always @(negedge clk_in) begin
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      case (c.kind)
        0: act = {2'b00, bus.data_out, bus.out_valid,
                  bus.out_first, bus.out_last, bus.overflow,
                  bus.underflow, bus.proto_err};
        1: act = {13'd0, bus.overflow, bus.underflow,
                  bus.proto_err};
        default: act = 16'(exp_q.size());
      endcase
      vectors++;
      if (act !== c.exp) begin
        miscompares++;
        $display("FAIL %s: got %h want %h",
                 c.name, act, c.exp);
      end
    end
    if (bus.out_valid && !ignore_out) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_out: got data %h, want none",
                 bus.data_out);
      end else begin
        e = exp_q.pop_front();
        if ({bus.data_out, bus.out_first, bus.out_last}
            !== {e.data, e.first, e.last} || cyc != e.stamp) begin
          miscompares++;
          $display("FAIL word: got %h f%b l%b @%0d want %h f%b l%b @%0d",
                   bus.data_out, bus.out_first, bus.out_last, cyc,
                   e.data, e.first, e.last, e.stamp);
        end
`ifdef BCH_CORR_STATS_EN
        if (e.last) begin
          vectors++;
          if ({bus.corr_bits, bus.cnt_mismatch} !== {e.bits, e.mis}) begin
            miscompares++;
            $display("FAIL stats: got bits %0d mis %b want %0d %b",
                     bus.corr_bits, bus.cnt_mismatch, e.bits, e.mis);
          end
        end
`endif
      end
    end
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_in();
    bus.start_in  = 1'b0;
    bus.err_valid = 1'b0;
    bus.err_first = 1'b0;
    bus.err_last  = 1'b0;
    bus.err_in    = '0;
  endtask

  task automatic check(input int kind, input logic [15:0] x,
                       input string nm);
    chk_q.push_back('{kind, x, nm});
  endtask

  task automatic write_words(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      step();
      bus.start_in = (i == 0);
      bus.data_in  = 8'(i) + b;
    end
  endtask

  task automatic read_cw(input logic [7:0] b,
                         input int i1, input logic [7:0] m1,
                         input int i2, input logic [7:0] m2,
                         input logic [7:0] cnt, input bit want);
    logic [15:0] nb;
    logic [7:0] mask;
    nb = 16'($countones(m1)) + 16'($countones(m2));
    for (int i = 0; i < DW; i++) begin
      step();
      bus.start_in = 1'b0;
      mask = (i == i1) ? m1 : ((i == i2) ? m2 : 8'h00);
      bus.err_valid = 1'b1;
      bus.err_first = (i == 0);
      bus.err_last  = (i == DW - 1);
      bus.err_in    = mask;
      bus.err_cnt   = cnt;
      if (want)
        exp_q.push_back('{(8'(i) + b) ^ mask, i == 0,
                          i == DW - 1, cyc + 2, nb,
                          nb != {8'd0, cnt}});
    end
    step();
    idle_in();
  endtask

  task automatic drain(input string nm);
    for (int k = 0; k < 50 && exp_q.size() > 0; k++) step();
    check(2, 16'd0, nm);
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.data_in = '0;
    bus.err_cnt = '0;
    idle_in();
    repeat (3) step();
    check(0, 16'd0, "reset_outputs");
    step();
    rst_n = 1'b1;
    step();

    // clean codeword, err_first 600 cycles after start
    write_words(8'h00, DW);
    repeat (64) step();
    read_cw(8'h00, -1, 8'h00, -1, 8'h00, 8'd0, 1'b1);
    drain("t1_drain");

    // two flipped bits, matching and mismatching err_cnt
    write_words(8'h00, DW);
    read_cw(8'h00, 3, 8'h01, 500, 8'h80, 8'd2, 1'b1);
    drain("t2a_drain");
    write_words(8'h00, DW);
    read_cw(8'h00, 3, 8'h01, 500, 8'h80, 8'd3, 1'b1);
    drain("t2b_drain");

    // two stored codewords, third dropped
    write_words(8'h10, DW);
    write_words(8'h20, DW);
    write_words(8'h30, DW);
    step();
    check(1, 16'b100, "overflow");
    read_cw(8'h10, -1, 8'h00, -1, 8'h00, 8'd1, 1'b1);
    read_cw(8'h20, 0, 8'hFF, -1, 8'h00, 8'd8, 1'b1);
    drain("t3_drain");

    // error stream with nothing stored
    read_cw(8'h00, -1, 8'h00, -1, 8'h00, 8'd0, 1'b0);
    drain("t4_no_out");
    check(1, 16'b110, "underflow");
    step();

    // restart at word 100 of a fill
    write_words(8'h40, 100);
    write_words(8'h55, DW);
    step();
    check(1, 16'b111, "proto_err");
    read_cw(8'h55, 7, 8'h5A, 535, 8'h01, 8'd5, 1'b1);
    drain("t5_drain");

    // reset in the middle of CORRECT
    write_words(8'h66, DW);
    ignore_out = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      bus.err_valid = 1'b1;
      bus.err_first = (i == 0);
      bus.err_last  = 1'b0;
      bus.err_in    = 8'h00;
    end
    step();
    rst_n = 1'b0;
    idle_in();
    check(0, 16'd0, "reset_mid_correct");
    step();
    step();
    ignore_out = 1'b0;
    rst_n = 1'b1;
    step();
    check(1, 16'd0, "flags_after_reset");
    write_words(8'h77, DW);
    read_cw(8'h77, 0, 8'hFF, 535, 8'h01, 8'd9, 1'b1);
    drain("t6_drain");
    step();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
